// File: rtl/dmac_pkg.sv
// -----------------------------------------------------------------------------
// dmac_pkg -- shared definitions for the DMA write engine.
//   * dmac_state_e     : write-engine FSM states
//   * AXI_* constants  : burst type, transfer size and response codes
//   * PAGE_BYTES/WORDS : AXI 4 KB page that no burst may cross
//   * page_room_words  : words left before the next 4 KB boundary
// -----------------------------------------------------------------------------
package dmac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } dmac_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_WORDS = PAGE_BYTES / 4;

  // Words remaining in the current 4 KB page, given the word offset
  // (address bits [11:2]) inside that page. Result is always 1..1024.
  function automatic logic [10:0] page_room_words(input logic [9:0] word_off);
    return 11'(PAGE_WORDS) - {1'b0, word_off};
  endfunction

endpackage

// File: rtl/dmac_burst_calc.sv
// -----------------------------------------------------------------------------
// dmac_burst_calc -- combinational burst sizer.
// beats_o = min(words_i, MAX_BURST, words left in the 4 KB page).
// Ports:
//   words_i    in  14        words still to transfer
//   word_off_i in  10        address bits [11:2] of the burst start
//   beats_o    out BEATS_W   beats for the next burst
// -----------------------------------------------------------------------------
module dmac_burst_calc
  import dmac_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int BEATS_W   = $clog2(MAX_BURST + 1)
) (
  input  logic [13:0]        words_i,
  input  logic [9:0]         word_off_i,
  output logic [BEATS_W-1:0] beats_o
);

  logic [10:0] room_s;
  logic [13:0] limit_s;

  assign room_s = page_room_words(word_off_i);

  // Smallest of remaining words, burst ceiling and page room.
  always_comb begin
    limit_s = 14'(MAX_BURST);
    if ({3'b000, room_s} < limit_s) begin
      limit_s = {3'b000, room_s};
    end else begin
      limit_s = 14'(MAX_BURST);
    end
    if (words_i < limit_s) begin
      beats_o = BEATS_W'(words_i);
    end else begin
      beats_o = BEATS_W'(limit_s);
    end
  end

endmodule

// File: rtl/dmac_wr_engine.sv
// -----------------------------------------------------------------------------
// dmac_wr_engine -- moves words from an upstream FIFO to memory as a series
// of AXI3 INCR write bursts (32-bit beats, full strobes, 4 KB-safe).
//
// Optional feature: define DMAC_WR_ERR_EN to add the sticky err_o output,
// set by any non-OKAY write response; without it bresp_i is ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  one-cycle request, honoured only while idle
//   dst_addr_i, byte_len_i   destination byte address, length in bytes
//   busy_o, done_o           transfer active, one-cycle completion pulse
//   fifo_empty_i/rden_o/rdata_i  upstream FIFO (show-ahead head word)
//   aw*_o/awready_i          AXI write-address channel
//   w*_o/wready_i            AXI write-data channel
//   bresp_i/bvalid_i/bready_o AXI write-response channel
//   err_o                    sticky response error (DMAC_WR_ERR_EN only)
// -----------------------------------------------------------------------------
module dmac_wr_engine
  import dmac_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [15:0]           byte_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic [3:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o
`ifdef DMAC_WR_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int BEATS_W = $clog2(MAX_BURST + 1);

  dmac_state_e          state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [13:0]           words_r;   // words left, including the current burst
  logic [BEATS_W-1:0]    beats_r;   // beats of the current burst
  logic [BEATS_W-1:0]    left_r;    // beats of the current burst not yet sent
  logic                  awvalid_r;
  logic                  wlast_r;
  logic                  bready_r;
  logic                  busy_r;
  logic                  done_r;

  logic [ADDR_WIDTH-1:0] calc_addr_s;
  logic [13:0]           calc_words_s;
  logic [BEATS_W-1:0]    calc_beats_s;
  logic                  w_hs_s;
  logic                  unused_len_s;

  // The burst sizer always looks at the burst that would start next: the
  // request inputs while idle, otherwise the position after this burst.
  // That lets IDLE and B load address, count and size in one edge.
  always_comb begin
    calc_addr_s  = addr_r;
    calc_words_s = words_r;
    if (state_r == ST_IDLE) begin
      calc_addr_s  = dst_addr_i & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
      calc_words_s = byte_len_i[15:2];
    end else begin
      calc_addr_s  = addr_r + ADDR_WIDTH'({beats_r, 2'b00});
      calc_words_s = words_r - 14'(beats_r);
    end
  end

  dmac_burst_calc #(
    .MAX_BURST (MAX_BURST),
    .BEATS_W   (BEATS_W)
  ) u_burst_calc (
    .words_i    (calc_words_s),
    .word_off_i (calc_addr_s[11:2]),
    .beats_o    (calc_beats_s)
  );

  // W channel follows the FIFO directly so a pop only happens on the
  // handshake; reset gates it so an abandoned burst pops nothing more.
  assign wvalid_o    = (state_r == ST_W) & ~fifo_empty_i & ~rst;
  assign w_hs_s      = wvalid_o & wready_i;
  assign fifo_rden_o = w_hs_s;
  assign wdata_o     = fifo_rdata_i;
  assign wstrb_o     = 4'hF;

  assign awaddr_o  = addr_r;
  assign awlen_o   = 4'(beats_r - BEATS_W'(1));
  assign awsize_o  = AXI_SIZE_4B;
  assign awburst_o = AXI_BURST_INCR;
  assign awvalid_o = awvalid_r;
  assign wlast_o   = wlast_r;
  assign bready_o  = bready_r;
  assign busy_o    = busy_r;
  assign done_o    = done_r;

  // Length bits below a word are discarded by design.
  assign unused_len_s = ^byte_len_i[1:0];

  // Transfer FSM with its registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      words_r   <= 14'd0;
      beats_r   <= '0;
      left_r    <= '0;
      awvalid_r <= 1'b0;
      wlast_r   <= 1'b0;
      bready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            addr_r  <= calc_addr_s;
            words_r <= calc_words_s;
            beats_r <= calc_beats_s;
            if (calc_words_s != 14'd0) begin
              state_r   <= ST_AW;
              awvalid_r <= 1'b1;
              busy_r    <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_AW: begin
          if (awready_i) begin
            awvalid_r <= 1'b0;
            left_r    <= beats_r;
            wlast_r   <= (beats_r == BEATS_W'(1));
            state_r   <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs_s) begin
            if (wlast_r) begin
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= ST_B;
            end else begin
              left_r  <= left_r - BEATS_W'(1);
              wlast_r <= (left_r == BEATS_W'(2));
            end
          end
        end
        ST_B: begin
          if (bvalid_i) begin
            bready_r <= 1'b0;
            addr_r   <= calc_addr_s;
            words_r  <= calc_words_s;
            beats_r  <= calc_beats_s;
            if (calc_words_s == 14'd0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r   <= ST_AW;
              awvalid_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          awvalid_r <= 1'b0;
          wlast_r   <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMAC_WR_ERR_EN
  logic err_r;

  // Sticky response error; a new accepted request starts it clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start_i) begin
      err_r <= 1'b0;
    end else if (bvalid_i && bready_r && (bresp_i != AXI_RESP_OKAY)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;
`else
  logic unused_bresp_s;
  assign unused_bresp_s = ^bresp_i;
`endif

endmodule

// File: tb/tb_dmac_wr_engine.sv
// -----------------------------------------------------------------------------
// tb_dmac_wr_engine -- self-checking bench for dmac_wr_engine.
// Each transfer is planned as a list of bursts computed with plain arithmetic
// (min of words left, 16, page room); a FIFO queue and an expected-data
// queue model the data path, and phase flags model the AXI handshakes.
// -----------------------------------------------------------------------------
module tb_dmac_wr_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] dst_addr_i;
  logic [15:0] byte_len_i;
  logic        busy_o, done_o;
  logic        fifo_empty_i, fifo_rden_o;
  logic [31:0] fifo_rdata_i;
  logic [31:0] awaddr_o;
  logic [3:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o, wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;
`ifdef DMAC_WR_ERR_EN
  logic        err_o;
  logic        exp_err;
`endif

  typedef struct {
    logic [31:0] a;
    int          b;
  } burst_t;

  burst_t      bq[$];
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmac_wr_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .dst_addr_i   (dst_addr_i),
    .byte_len_i   (byte_len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rden_o  (fifo_rden_o),
    .fifo_rdata_i (fifo_rdata_i),
    .awaddr_o     (awaddr_o),
    .awlen_o      (awlen_o),
    .awsize_o     (awsize_o),
    .awburst_o    (awburst_o),
    .awvalid_o    (awvalid_o),
    .awready_i    (awready_i),
    .wdata_o      (wdata_o),
    .wstrb_o      (wstrb_o),
    .wlast_o      (wlast_o),
    .wvalid_o     (wvalid_o),
    .wready_i     (wready_i),
    .bresp_i      (bresp_i),
    .bvalid_i     (bvalid_i),
    .bready_o     (bready_o)
`ifdef DMAC_WR_ERR_EN
    ,
    .err_o        (err_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i      = 1'b0;
    awready_i    = 1'b0;
    wready_i     = 1'b0;
    bvalid_i     = 1'b0;
    bresp_i      = 2'b00;
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_rdata_i = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},   busy_o,      64'd0);
    chk({tag, "_awv"},    awvalid_o,   64'd0);
    chk({tag, "_wv"},     wvalid_o,    64'd0);
    chk({tag, "_wlast"},  wlast_o,     64'd0);
    chk({tag, "_bready"}, bready_o,    64'd0);
    chk({tag, "_rden"},   fifo_rden_o, 64'd0);
  endtask

  // One transfer: plan bursts, fill FIFO, run handshakes with random
  // readiness, check every cycle. abort_at>0 resets after that many beats.
  task automatic do_xfer(input logic [31:0] addr, input int len, input int rdy_pct,
                         input bit stall, input int abort_at, input int err_burst);
    logic [31:0] a;
    logic [31:0] d;
    int w, b, room, words, left, total, cyc, bidx, stall_left;
    bit aw_pend, in_w, pend_b, fin, aborted, stalled, hs;
    bq.delete();
    words = len / 4;
    a = addr & 32'hFFFF_FFFC;
    w = words;
    while (w > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = w;
      if (b > 16) b = 16;
      if (b > room) b = room;
      bq.push_back('{a, b});
      a = a + 32'(b * 4);
      w = w - b;
    end
    for (int i = 0; i < words; i++) begin
      d = $urandom;
      fifo_q.push_back(d);
      exp_q.push_back(d);
    end

    idle_inputs();
    start_i    = 1'b1;
    dst_addr_i = addr;
    byte_len_i = 16'(len);
    #1;
    chk("pre_start_busy", busy_o, 64'd0);
    tick();
`ifdef DMAC_WR_ERR_EN
    exp_err = 1'b0;
`endif
    if (words == 0) begin
      idle_inputs();
      #1;
      chk("zero_done", done_o, 64'd1);
      chk_quiet("zero");
`ifdef DMAC_WR_ERR_EN
      chk("zero_err", err_o, 64'(exp_err));
`endif
      tick();
      #1;
      chk("zero_done_clr", done_o, 64'd0);
      chk("zero_awv", awvalid_o, 64'd0);
      return;
    end

    aw_pend = 1'b1; in_w = 1'b0; pend_b = 1'b0; fin = 1'b0; aborted = 1'b0;
    stalled = 1'b0; left = 0; total = 0; cyc = 0; bidx = 0; stall_left = 0;
    while (!fin) begin
      start_i    = ($urandom_range(0, 7) == 0);
      dst_addr_i = $urandom;
      byte_len_i = 16'($urandom);
      awready_i  = ($urandom_range(1, 100) <= rdy_pct);
      wready_i   = ($urandom_range(1, 100) <= rdy_pct);
      bvalid_i   = pend_b && ($urandom_range(1, 100) <= rdy_pct);
`ifdef DMAC_WR_ERR_EN
      bresp_i    = (bidx == err_burst) ? 2'b10 : 2'b00;
`else
      bresp_i    = 2'($urandom);
`endif
      fifo_empty_i = (fifo_q.size() == 0) || (stall_left > 0);
      fifo_rdata_i = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
      if (stall_left > 0) stall_left--;
      #1;
      chk("busy", busy_o, 64'd1);
      chk("done_early", done_o, 64'd0);
      chk("awvalid", awvalid_o, 64'(aw_pend));
      chk("bready", bready_o, 64'(pend_b));
      chk("wvalid", wvalid_o, 64'(in_w && !fifo_empty_i));
`ifdef DMAC_WR_ERR_EN
      chk("err", err_o, 64'(exp_err));
`endif
      if (aw_pend) begin
        chk("awaddr", awaddr_o, 64'(bq[0].a));
        chk("awlen", awlen_o, 64'(bq[0].b - 1));
        chk("awsize", awsize_o, 64'd2);
        chk("awburst", awburst_o, 64'd1);
        if (awready_i) begin
          aw_pend = 1'b0;
          in_w    = 1'b1;
          left    = bq[0].b;
        end
      end
      if (pend_b && bvalid_i) begin
`ifdef DMAC_WR_ERR_EN
        if (bresp_i != 2'b00) exp_err = 1'b1;
`endif
        pend_b = 1'b0;
        bq.pop_front();
        bidx++;
        if (bq.size() == 0) fin = 1'b1;
        else aw_pend = 1'b1;
      end
      hs = wvalid_o && wready_i;
      chk("rden", fifo_rden_o, 64'(hs));
      if (fifo_rden_o && fifo_q.size() > 0) fifo_q.pop_front();
      if (in_w && hs) begin
        if (exp_q.size() == 0) begin
          chk("wdata_extra", 64'd1, 64'd0);
        end else begin
          chk("wdata", wdata_o, 64'(exp_q[0]));
          exp_q.pop_front();
        end
        chk("wlast", wlast_o, 64'(left == 1));
        chk("wstrb", wstrb_o, 64'hF);
        left--;
        total++;
        if (stall && !stalled && total == 2 && left > 0) begin
          stall_left = 5;
          stalled    = 1'b1;
        end
        if (left == 0) begin
          in_w   = 1'b0;
          pend_b = 1'b1;
        end
      end
      if (abort_at > 0 && total == abort_at) begin
        aborted = 1'b1;
        break;
      end
      cyc++;
      if (cyc > 4000) begin
        chk("timeout", 64'd1, 64'd0);
        fin = 1'b1;
      end
      tick();
    end

    if (aborted) begin
      rst       = 1'b1;
      wready_i  = 1'b1;
      awready_i = 1'b1;
      #1;
      chk("rst_cycle_rden", fifo_rden_o, 64'd0);
      tick();
      chk_quiet("rst");
      chk("rst_done", done_o, 64'd0);
`ifdef DMAC_WR_ERR_EN
      chk("rst_err", err_o, 64'd0);
`endif
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        idle_inputs();
        wready_i = 1'b1;
        #1;
        chk("post_rst_done", done_o, 64'd0);
        chk("post_rst_rden", fifo_rden_o, 64'd0);
        chk("post_rst_busy", busy_o, 64'd0);
        tick();
      end
      fifo_q.delete();
      exp_q.delete();
      return;
    end

    idle_inputs();
    #1;
    chk("done", done_o, 64'd1);
    chk_quiet("end");
    chk("data_left", 64'(exp_q.size()), 64'd0);
    chk("fifo_left", 64'(fifo_q.size()), 64'd0);
`ifdef DMAC_WR_ERR_EN
    chk("end_err", err_o, 64'(exp_err));
`endif
    tick();
    #1;
    chk("done_clr", done_o, 64'd0);
`ifdef DMAC_WR_ERR_EN
    chk("err_hold", err_o, 64'(exp_err));
`endif
  endtask

  initial begin
    logic [31:0] ra;
    rst        = 1'b1;
    dst_addr_i = 32'h0;
    byte_len_i = 16'h0;
    idle_inputs();
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_done", done_o, 64'd0);
`ifdef DMAC_WR_ERR_EN
    chk("reset_err", err_o, 64'd0);
`endif
    rst = 1'b0;
    tick();

    do_xfer(32'h0000_1000, 64, 100, 1'b0, 0, -1);  // single 16-beat burst
    do_xfer(32'h0000_0FF8, 32, 100, 1'b0, 0, -1);  // split at 4 KB: 2 + 6
    do_xfer(32'h0000_2000, 0, 100, 1'b0, 0, -1);   // zero length
    do_xfer(32'h0000_2000, 3, 100, 1'b0, 0, -1);   // sub-word length
    do_xfer(32'h0000_3010, 120, 60, 1'b1, 0, -1);  // FIFO stall, random ready
    do_xfer(32'h0000_4000, 64, 100, 1'b0, 3, -1);  // reset after 3 beats
    do_xfer(32'h0000_5004, 40, 70, 1'b0, 0, -1);   // restart after reset
    do_xfer(32'hFFFF_FFF0, 64, 80, 1'b0, 0, -1);   // address wrap
    do_xfer(32'h0000_0FF8, 32, 100, 1'b0, 0, 0);   // error response on burst 0
    do_xfer(32'h0000_6000, 16, 100, 1'b0, 0, -1);  // next start clears error
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      ra[11:8] = 4'hF;
      do_xfer(ra, $urandom_range(0, 400), $urandom_range(30, 100),
              1'($urandom_range(0, 1)), 0, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmac_wr_engine.md
DMAC_WR_ENGINE -- requirements
Module: dmac_wr_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, AXI write-data and FIFO-data width (fixed 32 in this release).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 The block SHALL have parameter MAX_BURST, default 16, maximum beats per AXI burst (AXI3, awlen 4 bits).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports and all others listed below:
  clk  in  1  sole clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  start_i  in  1  one-cycle transfer request
  dst_addr_i  in  ADDR_WIDTH  destination byte address
  byte_len_i  in  16  transfer length in bytes
  busy_o  out  1  transfer in progress
  done_o  out  1  one-cycle completion pulse
  fifo_empty_i  in  1  upstream FIFO empty flag
  fifo_rden_o  out  1  FIFO pop
  fifo_rdata_i  in  DATA_WIDTH  FIFO head word (registered, valid when not empty)
  awaddr_o  out  ADDR_WIDTH, awlen_o  out  4, awsize_o  out  3, awburst_o  out  2, awvalid_o  out  1, awready_i  in  1  AXI AW channel
  wdata_o  out  DATA_WIDTH, wstrb_o  out  4, wlast_o  out  1, wvalid_o  out  1, wready_i  in  1  AXI W channel
  bresp_i  in  2, bvalid_i  in  1, bready_o  out  1  AXI B channel
  err_o  out  1  sticky write-response error (only with DMAC_WR_ERR_EN)

Function
REQ-005 FSM states SHALL be IDLE, AW, W, B; start_i SHALL be honoured only in IDLE and ignored elsewhere.
REQ-006 On start_i in IDLE the block SHALL latch dst_addr_i with bits [1:0] forced to 0 and remaining words = byte_len_i[15:2] (bits [1:0] discarded).
REQ-007 If latched word count is 0, the block SHALL pulse done_o in the next cycle, stay in IDLE, and issue no AXI or FIFO activity.
REQ-008 Otherwise the block SHALL enter AW the next cycle; busy_o SHALL be 1 in AW, W, B and 0 in IDLE.
REQ-009 Burst beats SHALL be min(remaining words, MAX_BURST, (4096 - addr[11:0])/4), so no burst crosses a 4 KB boundary.
REQ-010 In AW: awvalid_o=1, awaddr_o=current address, awlen_o=beats-1, awsize_o=3'b010, awburst_o=2'b01 (INCR); all held stable until awready_i, then go to W.
REQ-011 In W: wvalid_o = ~fifo_empty_i, wdata_o = fifo_rdata_i, wstrb_o = 4'hF, fifo_rden_o = wvalid_o & wready_i (pop only on handshake).
REQ-012 wlast_o SHALL be 1 exactly on the final beat of each burst; after the wlast handshake go to B.
REQ-013 In B: bready_o=1; on bvalid_i, address += beats*4 and remaining -= beats; if remaining is 0, go to IDLE with a one-cycle done_o pulse, else go to AW.
REQ-014 awvalid_o, wvalid_o, bready_o and fifo_rden_o SHALL be 0 in every state other than their own.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH with no error.

Reset
REQ-016 On rst, at the next edge: state=IDLE, busy_o=0, done_o=0, awvalid_o=0, wvalid_o=0, wlast_o=0, bready_o=0, fifo_rden_o=0, err_o=0, counters and address=0.
REQ-017 Reset mid-transfer SHALL abandon the transfer with no further FIFO pops and no done_o pulse.

Configuration
REQ-018 With DMAC_WR_ERR_EN defined, err_o SHALL set when bvalid_i & bready_o & bresp_i != 2'b00, clear only on rst or an accepted start_i, and the transfer SHALL still complete.
REQ-019 Without DMAC_WR_ERR_EN, port err_o and its logic SHALL be absent, and bresp_i SHALL be ignored.

Structure
REQ-020 Shared package dmac_pkg SHALL hold the FSM state enum, AXI burst/size/resp constants, and the 4 KB page constant.
REQ-021 Burst-length computation SHALL be one combinational sub-module, dmac_burst_calc.

Verification
REQ-022 start, addr 0x1000, len 64, FIFO pre-filled with 16 words, all ready=1 -> one AW with awlen 15, 16 W beats, wlast on beat 16, done_o one cycle after bvalid.
REQ-023 addr 0x0FF8, len 32 -> two bursts: awaddr 0x0FF8 with awlen 1, then 0x1000 with awlen 5.
REQ-024 len 0 -> done_o pulses the cycle after start with no awvalid; len 3 behaves identically.
REQ-025 FIFO empty for 5 cycles mid-burst, wready random -> no pop without handshake, data order preserved, wvalid_o low while empty.
REQ-026 rst asserted in W after 3 beats -> all outputs 0 at the next edge, no done_o; a new start then succeeds.
REQ-027 With DMAC_WR_ERR_EN, bresp 2'b10 on the first of two bursts -> err_o=1 and stays 1, done_o still pulses; the next start clears err_o.
